phase_timer: RTL and testbench

//   Responder side of the controller's state interface. Watches the 9-bit one-hot

---
 rtl/phase_timer.sv | 115 +++++++++++
 tb/tb_phase_timer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// Phase timer: watches the controller's one-hot state vector, times each timed
// phase in prescaled ticks and returns a level done flag for the phase that expired.
module phase_timer #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 8,
   parameter int DELAY_T  = 2,
   parameter int FILL_T   = 5,
   parameter int WASH_T   = 10,
   parameter int RINSE_T  = 6,
   parameter int SPIN_T   = 8,
   parameter int DRAIN_T  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [8:0]       state,
   output logic             sig_Delay,
   output logic             sig_Full,
   output logic             sig_Wash_Completed,
   output logic             sig_Rinse_Completed,
   output logic             sig_Spin_Completed,
   output logic             sig_Drain_Completed,
   output logic [CNT_W-1:0] remaining_ticks,
   output logic             state_error
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [8:0] ST_IDLE = 9'b0_0000_0001;

   typedef enum logic [2:0] {
      PH_NONE, PH_READY, PH_FILL, PH_WASH, PH_RINSE, PH_SPIN, PH_DRAIN
   } phase_e;

   logic [8:0]       state_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       done_q, done_d;
   logic             err_q, err_d;

   phase_e           phase;
   logic [CNT_W-1:0] load_val;
   logic [5:0]       done_sel;
   logic             one_hot;

   // Only an exact one-hot timed encoding selects a phase; anything else is untimed.
   always_comb begin
      phase    = PH_NONE;
      load_val = '0;
      done_sel = '0;
      one_hot  = (state != 9'd0) && ((state & (state - 9'd1)) == 9'd0);
      case (state)
         9'b0_0000_0010: begin phase = PH_READY; load_val = CNT_W'(DELAY_T); done_sel = 6'b000001; end
         9'b0_0000_0100: begin phase = PH_FILL;  load_val = CNT_W'(FILL_T);  done_sel = 6'b000010; end
         9'b0_0000_1000: begin phase = PH_WASH;  load_val = CNT_W'(WASH_T);  done_sel = 6'b000100; end
         9'b0_0001_0000: begin phase = PH_RINSE; load_val = CNT_W'(RINSE_T); done_sel = 6'b001000; end
         9'b0_0010_0000: begin phase = PH_SPIN;  load_val = CNT_W'(SPIN_T);  done_sel = 6'b010000; end
         9'b0_0100_0000: begin phase = PH_DRAIN; load_val = CNT_W'(DRAIN_T); done_sel = 6'b100000; end
         default: ;
      endcase
   end

   // Priority: untimed/illegal clears, then entry reloads, then tick counting.
   // A state change therefore always beats an expiry in the same cycle.
   always_comb begin
      pre_d  = pre_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      err_d  = ~one_hot;
      if (phase == PH_NONE) begin
         pre_d  = '0;
         cnt_d  = '0;
         done_d = '0;
      end else if (state != state_q) begin
         pre_d  = '0;
         cnt_d  = load_val;
         done_d = '0;
      end else if (cnt_q != '0) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               done_d = done_sel;
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         cnt_q   <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign sig_Delay           = done_q[0];
   assign sig_Full            = done_q[1];
   assign sig_Wash_Completed  = done_q[2];
   assign sig_Rinse_Completed = done_q[3];
   assign sig_Spin_Completed  = done_q[4];
   assign sig_Drain_Completed = done_q[5];
   assign remaining_ticks     = cnt_q;
   assign state_error         = err_q;

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer: directed phase scenarios plus random state streams,
// checked cycle by cycle against an elapsed-time model of each phase.
module tb_phase_timer;

   localparam int TD      = 4;
   localparam int CNT_W   = 8;
   localparam int DELAY_T = 2;
   localparam int FILL_T  = 5;
   localparam int WASH_T  = 10;
   localparam int RINSE_T = 6;
   localparam int SPIN_T  = 8;
   localparam int DRAIN_T = 4;
   localparam int VW      = 1 + CNT_W + 6;

   localparam logic [8:0] S_IDLE  = 9'b0_0000_0001;
   localparam logic [8:0] S_READY = 9'b0_0000_0010;
   localparam logic [8:0] S_FILL  = 9'b0_0000_0100;
   localparam logic [8:0] S_WASH  = 9'b0_0000_1000;
   localparam logic [8:0] S_RINSE = 9'b0_0001_0000;
   localparam logic [8:0] S_SPIN  = 9'b0_0010_0000;
   localparam logic [8:0] S_DRAIN = 9'b0_0100_0000;
   localparam logic [8:0] S_ERROR = 9'b1_0000_0000;

   logic             clock;
   logic             reset;
   logic [8:0]       state;
   logic             sig_Delay, sig_Full, sig_Wash_Completed;
   logic             sig_Rinse_Completed, sig_Spin_Completed, sig_Drain_Completed;
   logic [CNT_W-1:0] remaining_ticks;
   logic             state_error;
   logic [5:0]       done_vec;

   int tests_run    = 0;
   int tests_failed = 0;
   int cycle        = 0;

   logic [VW-1:0] exp_q[$];

   phase_timer #(
      .TICK_DIV(TD), .CNT_W(CNT_W), .DELAY_T(DELAY_T), .FILL_T(FILL_T),
      .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T), .DRAIN_T(DRAIN_T)
   ) dut (
      .clock(clock), .reset(reset), .state(state),
      .sig_Delay(sig_Delay), .sig_Full(sig_Full),
      .sig_Wash_Completed(sig_Wash_Completed), .sig_Rinse_Completed(sig_Rinse_Completed),
      .sig_Spin_Completed(sig_Spin_Completed), .sig_Drain_Completed(sig_Drain_Completed),
      .remaining_ticks(remaining_ticks), .state_error(state_error)
   );

   assign done_vec = {sig_Drain_Completed, sig_Spin_Completed, sig_Rinse_Completed,
                      sig_Wash_Completed, sig_Full, sig_Delay};

   // ---------------- clock / reset ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(posedge clock) cycle++;

   // ---------------- reference model ----------------
   function automatic int phase_ticks(input logic [8:0] s);
      case (s)
         S_READY: return DELAY_T;
         S_FILL:  return FILL_T;
         S_WASH:  return WASH_T;
         S_RINSE: return RINSE_T;
         S_SPIN:  return SPIN_T;
         S_DRAIN: return DRAIN_T;
         default: return 0;
      endcase
   endfunction

   function automatic int phase_idx(input logic [8:0] s);
      case (s)
         S_READY: return 0;
         S_FILL:  return 1;
         S_WASH:  return 2;
         S_RINSE: return 3;
         S_SPIN:  return 4;
         default: return 5;
      endcase
   endfunction

   // Model tracks how many edges the current timed phase has been held since entry;
   // remaining ticks and expiry follow from that elapsed count by plain arithmetic.
   logic [8:0] m_prev = S_IDLE;
   int         m_age  = -1;

   always @(posedge clock) begin
      int            t;
      int            rem;
      logic [5:0]    dn;
      logic          er;
      if (!reset) begin
         m_prev = S_IDLE;
         m_age  = -1;
         exp_q.push_back('0);
      end else begin
         t = phase_ticks(state);
         if (t == 0)                m_age = -1;
         else if (state != m_prev)  m_age = 0;
         else if (m_age < 100000)   m_age = m_age + 1;
         m_prev = state;
         er  = ($countones(state) != 1);
         rem = 0;
         dn  = '0;
         if (m_age >= 0) begin
            if (m_age >= t * TD) dn[phase_idx(state)] = 1'b1;
            else                 rem = t - m_age / TD;
         end
         exp_q.push_back({er, CNT_W'(rem), dn});
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clock) begin
      logic [VW-1:0] e;
      logic [VW-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {state_error, remaining_ticks, done_vec};
         tests_run++;
         if (a !== e) begin
            tests_failed++;
            $display("FAIL outputs cycle %0d: got err=%b rem=%0d done=%b, expected err=%b rem=%0d done=%b",
                     cycle, a[VW-1], a[VW-2:6], a[5:0], e[VW-1], e[VW-2:6], e[5:0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
      end
   endtask

   // Counts falling edges from now until done bit idx is seen high.
   task automatic wait_done(input string name, input int idx, input int exp_cycles);
      int n;
      n = 0;
      while (n < 400) begin
         @(negedge clock);
         n++;
         if (done_vec[idx]) break;
      end
      check(name, n, exp_cycles);
   endtask

   task automatic wait_rem(input string name, input int val);
      int n;
      n = 0;
      while (n < 400) begin
         @(negedge clock);
         n++;
         if (remaining_ticks == CNT_W'(val)) break;
      end
      check(name, int'(remaining_ticks), val);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         hold;
      logic [8:0] s;
      reset = 1'b0;
      state = S_FILL;
      repeat (3) @(negedge clock);
      check("reset_outputs", int'({state_error, remaining_ticks, done_vec}), 0);

      // Release with FILL already present: counts as an entry.
      reset = 1'b1;
      wait_done("fill_after_reset", 1, FILL_T * TD + 1);

      // Full sequence, advancing on each done.
      state = S_READY; wait_done("ready_lat", 0, DELAY_T * TD + 1);
      state = S_FILL;  wait_done("fill_lat",  1, FILL_T * TD + 1);
      state = S_WASH;  wait_done("wash_lat",  2, WASH_T * TD + 1);
      state = S_RINSE; wait_done("rinse_lat", 3, RINSE_T * TD + 1);
      state = S_SPIN;  wait_done("spin_lat",  4, SPIN_T * TD + 1);
      state = S_DRAIN; wait_done("drain_lat", 5, DRAIN_T * TD + 1);

      // WASH interrupted by ERROR, then returned to.
      state = S_WASH;
      wait_rem("wash_rem3", 3);
      state = S_ERROR;
      repeat (2) @(negedge clock);
      state = S_WASH;
      @(negedge clock);
      check("wash_reload", int'(remaining_ticks), WASH_T);
      wait_done("wash_relat", 2, WASH_T * TD);

      // Illegal encodings, then FILL restarts a full count.
      state = 9'b0_0000_1100;
      @(negedge clock);
      check("err_two_hot", int'(state_error), 1);
      state = 9'b0;
      @(negedge clock);
      check("err_zero", int'(state_error), 1);
      state = S_FILL;
      wait_done("fill_after_err", 1, FILL_T * TD + 1);

      // Async reset mid-SPIN.
      state = S_SPIN;
      wait_rem("spin_rem5", 5);
      #1 reset = 1'b0;
      #1 check("async_clear", int'({remaining_ticks, done_vec}), 0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      wait_done("spin_fresh", 4, SPIN_T * TD + 1);

      // State change on the exact expiry cycle of FILL.
      state = S_FILL;
      repeat (FILL_T * TD) @(negedge clock);
      state = S_RINSE;
      @(negedge clock);
      check("fill_suppressed", int'(sig_Full), 0);
      check("rinse_loaded", int'(remaining_ticks), RINSE_T);
      wait_done("rinse_after", 3, RINSE_T * TD);

      // Random state streams with occasional async reset pulses.
      for (int seg = 0; seg < 40; seg++) begin
         if ($urandom_range(0, 4) == 0) s = 9'($urandom_range(0, 511));
         else                           s = 9'b1 << $urandom_range(0, 8);
         state = s;
         hold = $urandom_range(1, 45);
         repeat (hold) @(negedge clock);
         if ($urandom_range(0, 14) == 0) begin
            #1 reset = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clock);
            reset = 1'b1;
         end
      end

      repeat (3) @(negedge clock);
      @(posedge clock);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
